lcd_cmd_sequencer: RTL and testbench
====================================

# lcd_cmd_sequencer

Avalon-MM master that sits directly upstream of the 16207 character-LCD Avalon slave and is the only agent driving its control port. It accepts command and character bytes over a valid/ready stream and runs the HD44780 power-up init sequence. Every byte becomes a correctly timed slave access: address setup, stretched E strobe and hold. After each byte it polls the busy flag before accepting the next one. The slave maps address[0] to RW and address[1] to RS, and drives E = read | write, so all LCD bus timing is created here.

## Interface
- POWERUP_CYCLES, 750000: idle wait after reset before the first init access (15 ms at 50 MHz).
- SETUP_CYCLES, 3: cycles address/writedata are held with read/write low before the strobe.
- E_HOLD_CYCLES, 13: cycles read or write (and therefore LCD E) is held high.
- HOLD_CYCLES, 13: cycles address/writedata are held after the strobe falls.
- INIT_GAP_CYCLES, 250000: fixed wait after each of the first three init writes (no busy polling).
- POLL_LIMIT, 4096: maximum status reads per byte before timeout.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  byte available.
- in_ready  out  1  block accepts a byte this cycle.
- in_rs  in  1  0 = command, 1 = character data.
- in_data  in  8  byte to send.
- init_done  out  1  init sequence complete; sticky until reset.
- busy  out  1  high whenever the FSM is not in IDLE.
- error  out  1  sticky poll-timeout flag; cleared only by reset.
- av_address  out  2  {RS, RW} to the slave.
- av_read  out  1  slave read strobe.
- av_write  out  1  slave write strobe.
- av_writedata  out  8  slave write data.
- av_readdata  in  8  slave read data; bit 7 is the busy flag.

## Operation
- Reset values: av_read=0, av_write=0, av_address=0, av_writedata=0x00, in_ready=0, init_done=0, error=0, busy=1. The FSM enters PWRUP.
- States: PWRUP, INIT_ISSUE, INIT_GAP, IDLE, SETUP, STROBE, HOLD, POLL_SETUP, POLL_STROBE, POLL_HOLD.
- PWRUP: counts POWERUP_CYCLES, then goes to INIT_ISSUE with the init index at 0.
- Init ROM, in order: 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06. All entries are commands (address 0).
  - Entries 0–2 are followed by INIT_GAP.
  - Entries 3–5 are followed by busy polling.
  - After entry 5 completes, init_done rises and the FSM goes to IDLE.
- IDLE: in_ready = init_done. On in_valid & in_ready, the byte is latched. av_address = {in_rs, 0} and av_writedata = in_data, then the FSM goes to SETUP.
- Write access:
  - SETUP: SETUP_CYCLES cycles, strobes low.
  - STROBE: E_HOLD_CYCLES cycles, av_write=1.
  - HOLD: HOLD_CYCLES cycles, strobes low, address and data unchanged.
- Poll access:
  - av_address = 2'b01.
  - POLL_SETUP / POLL_STROBE (av_read=1) / POLL_HOLD use the same counts as a write access.
  - av_readdata is sampled on the last POLL_STROBE cycle.
  - Sampled bit 7 = 1: increment the poll count. If the count reaches POLL_LIMIT, set error and return to IDLE (or continue init). Otherwise repeat POLL_SETUP.
  - Sampled bit 7 = 0: the byte is complete.
- Mid-init timeout: error is set and init continues with the next ROM entry.
- av_read and av_write are never high together. Both are low in every state except STROBE / POLL_STROBE.
- Reset mid-access: strobes drop on the next edge and the full power-up/init sequence reruns.

## Timing
- Accept to av_write rising: exactly SETUP_CYCLES+1 cycles. Latching the byte takes 1 cycle.
- av_write is high for exactly E_HOLD_CYCLES consecutive cycles.
- Minimum E-low time between two strobes is HOLD_CYCLES+SETUP_CYCLES cycles. This guarantees ≥500 ns E cycle at defaults.
- in_ready is high only in IDLE. It deasserts the cycle after acceptance and stays low until the busy-flag poll completes.
- Counters are wide enough for POWERUP_CYCLES. All terminal comparisons are at count == N−1.
- A write access or one poll iteration occupies SETUP+E_HOLD+HOLD cycles.

## Test plan
Unless stated, use sim parameters POWERUP=20, SETUP=2, E_HOLD=4, HOLD=2, INIT_GAP=10, POLL_LIMIT=3.
1. Reset then idle, readdata=0x00 → six av_write pulses with writedata 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06, each 4 cycles wide at address 0. The first write rises on cycle 20+2+1 after reset release. init_done rises after the last poll.
2. After init, send in_rs=1, in_data=0x41 → av_address=2, writedata=0x41, write high for 4 cycles. Then one read at address 1. in_ready returns 1 after POLL_HOLD.
3. Hold readdata=0x80 for two polls, then 0x00 → exactly 3 av_read pulses before in_ready reasserts, and error stays 0.
4. Hold readdata=0x80 permanently after a command → exactly 3 polls, then error=1 and in_ready=1. error persists through further bytes until reset.
5. Assert reset during STROBE of a data write → av_write=0 on the next edge, init_done=0, and the init sequence restarts from 0x38.
6. Back-to-back in_valid with idle LCD → a second byte is accepted only after the first byte's poll completes. Strobe gaps are ≥4 cycles and read/write never overlap.

Source files
------------

// File: rtl/lcd_cmd_sequencer.sv
// Avalon-MM master for the 16207 character-LCD slave: runs the HD44780 init
// sequence, then turns each streamed byte into a timed write followed by busy-flag polling.
module lcd_cmd_sequencer #(
    parameter int unsigned POWERUP_CYCLES  = 750000,
    parameter int unsigned SETUP_CYCLES    = 3,
    parameter int unsigned E_HOLD_CYCLES   = 13,
    parameter int unsigned HOLD_CYCLES     = 13,
    parameter int unsigned INIT_GAP_CYCLES = 250000,
    parameter int unsigned POLL_LIMIT      = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_rs,
    input  logic [7:0] in_data,
    output logic       init_done,
    output logic       busy,
    output logic       error,
    output logic [1:0] av_address,
    output logic       av_read,
    output logic       av_write,
    output logic [7:0] av_writedata,
    input  logic [7:0] av_readdata
);
    localparam int unsigned MAX_A  = (POWERUP_CYCLES > INIT_GAP_CYCLES) ? POWERUP_CYCLES : INIT_GAP_CYCLES;
    localparam int unsigned MAX_B  = (SETUP_CYCLES > E_HOLD_CYCLES) ? SETUP_CYCLES : E_HOLD_CYCLES;
    localparam int unsigned MAX_C  = (MAX_B > HOLD_CYCLES) ? MAX_B : HOLD_CYCLES;
    localparam int unsigned MAX_N  = (MAX_A > MAX_C) ? MAX_A : MAX_C;
    localparam int unsigned CNT_W  = $clog2(MAX_N + 1);
    localparam int unsigned POLL_W = $clog2(POLL_LIMIT + 1);

    typedef enum logic [3:0] {
        PWRUP, INIT_ISSUE, INIT_GAP, IDLE, SETUP, STROBE, HOLD,
        POLL_SETUP, POLL_STROBE, POLL_HOLD
    } state_t;

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [POLL_W-1:0]   poll_cnt, poll_cnt_n, poll_inc;
    logic [2:0]          init_idx, init_idx_n;
    logic [1:0]          addr_n;
    logic [7:0]          wdata_n;
    logic                init_done_n, error_n;
    logic                busy_flag, busy_flag_n;
    logic                cnt_last, byte_done;
    int unsigned         lim;
    logic                readdata_unused;

    assign readdata_unused = ^av_readdata[6:0];

    function automatic logic [7:0] init_rom(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2: return 8'h38;
            3'd3:             return 8'h0C;
            3'd4:             return 8'h01;
            3'd5:             return 8'h06;
            default:          return 8'h00;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= PWRUP;
            cnt          <= '0;
            poll_cnt     <= '0;
            init_idx     <= '0;
            av_address   <= '0;
            av_writedata <= '0;
            init_done    <= 1'b0;
            error        <= 1'b0;
            busy_flag    <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            poll_cnt     <= poll_cnt_n;
            init_idx     <= init_idx_n;
            av_address   <= addr_n;
            av_writedata <= wdata_n;
            init_done    <= init_done_n;
            error        <= error_n;
            busy_flag    <= busy_flag_n;
        end
    end

    assign av_read  = (state == POLL_STROBE);
    assign av_write = (state == STROBE);
    assign busy     = (state != IDLE);
    assign in_ready = (state == IDLE) && init_done;
    assign poll_inc = poll_cnt + POLL_W'(1);

    always_comb begin
        case (state)
            PWRUP:                 lim = POWERUP_CYCLES;
            INIT_GAP:              lim = INIT_GAP_CYCLES;
            SETUP, POLL_SETUP:     lim = SETUP_CYCLES;
            STROBE, POLL_STROBE:   lim = E_HOLD_CYCLES;
            HOLD, POLL_HOLD:       lim = HOLD_CYCLES;
            default:               lim = 1;
        endcase
        cnt_last = (cnt == CNT_W'(lim - 1));
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt_last ? '0 : cnt + 1'b1;
        poll_cnt_n  = poll_cnt;
        init_idx_n  = init_idx;
        addr_n      = av_address;
        wdata_n     = av_writedata;
        init_done_n = init_done;
        error_n     = error;
        busy_flag_n = busy_flag;
        byte_done   = 1'b0;

        case (state)
            PWRUP: if (cnt_last) begin
                state_n    = INIT_ISSUE;
                init_idx_n = '0;
            end
            INIT_ISSUE: begin
                addr_n  = 2'b00;
                wdata_n = init_rom(init_idx);
                state_n = SETUP;
            end
            INIT_GAP: if (cnt_last) begin
                init_idx_n = init_idx + 3'd1;
                state_n    = INIT_ISSUE;
            end
            IDLE: if (in_valid && init_done) begin
                addr_n  = {in_rs, 1'b0};
                wdata_n = in_data;
                state_n = SETUP;
            end
            SETUP:  if (cnt_last) state_n = STROBE;
            STROBE: if (cnt_last) state_n = HOLD;
            HOLD: if (cnt_last) begin
                // The first three function-set writes cannot be polled; wait them out
                if (!init_done && init_idx < 3'd3) begin
                    state_n = INIT_GAP;
                end else begin
                    state_n    = POLL_SETUP;
                    poll_cnt_n = '0;
                    addr_n     = 2'b01;
                end
            end
            POLL_SETUP: if (cnt_last) state_n = POLL_STROBE;
            POLL_STROBE: if (cnt_last) begin
                busy_flag_n = av_readdata[7];
                state_n     = POLL_HOLD;
            end
            POLL_HOLD: if (cnt_last) begin
                if (!busy_flag) begin
                    byte_done = 1'b1;
                end else if (poll_inc == POLL_W'(POLL_LIMIT)) begin
                    error_n   = 1'b1;
                    byte_done = 1'b1;
                end else begin
                    poll_cnt_n = poll_inc;
                    state_n    = POLL_SETUP;
                end
            end
            default: state_n = PWRUP;
        endcase

        if (byte_done) begin
            if (init_done) begin
                state_n = IDLE;
            end else if (init_idx == 3'd5) begin
                init_done_n = 1'b1;
                state_n     = IDLE;
            end else begin
                init_idx_n = init_idx + 3'd1;
                state_n    = INIT_ISSUE;
            end
        end
    end
endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Self-checking bench: a timeline model expands each init step / accepted byte into
// per-cycle expected bus activity and drives the busy flag the model has chosen.
module tb_lcd_cmd_sequencer;
    localparam int P_PWR  = 20;
    localparam int P_SET  = 2;
    localparam int P_EH   = 4;
    localparam int P_HOLD = 2;
    localparam int P_GAP  = 10;
    localparam int P_PL   = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_rs = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic [7:0] av_readdata = 8'h00;
    logic       in_ready, init_done, busy, error, av_read, av_write;
    logic [1:0] av_address;
    logic [7:0] av_writedata;

    always #5 clk = ~clk;

    lcd_cmd_sequencer #(
        .POWERUP_CYCLES (P_PWR),
        .SETUP_CYCLES   (P_SET),
        .E_HOLD_CYCLES  (P_EH),
        .HOLD_CYCLES    (P_HOLD),
        .INIT_GAP_CYCLES(P_GAP),
        .POLL_LIMIT     (P_PL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_rs       (in_rs),
        .in_data     (in_data),
        .init_done   (init_done),
        .busy        (busy),
        .error       (error),
        .av_address  (av_address),
        .av_read     (av_read),
        .av_write    (av_write),
        .av_writedata(av_writedata),
        .av_readdata (av_readdata)
    );

    typedef struct packed {
        logic       rd;
        logic       wr;
        logic [1:0] addr;
        logic [7:0] wdata;
        logic       rdy;
        logic       bsy;
        logic       idone;
        logic       err;
    } obs_t;

    typedef struct packed {
        obs_t       o;
        logic [7:0] rdata;
    } rec_t;

    rec_t       exp_q[$];
    logic [1:0] m_addr;
    logic [7:0] m_wdata;
    logic       m_idone, m_err;
    int         poll_mode;
    int         n_checks, n_fail;
    bit         model_on;
    bit         drv_rst, drv_valid, drv_rs;
    logic [7:0] drv_data;
    bit         last_acc;
    int         cyc, cyc_next, acc_cyc;
    bit         prev_wr, prev_rd, prev_strobe, prev_idone, seen_strobe;
    int         rd_pulses, low_run, idone_cyc;
    int         wr_cyc[$];
    logic [7:0] wr_dat[$];
    logic [1:0] wr_adr[$];
    logic [7:0] rom[6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic check_min(input string name, input int got, input int min);
        n_checks++;
        if (got < min) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected at least %0d", name, got, min);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    function automatic logic [7:0] rnd8();
        return 8'($urandom);
    endfunction

    task automatic push(input bit rd, input bit wr, input logic [7:0] rdata);
        rec_t r;
        r.o     = '{rd: rd, wr: wr, addr: m_addr, wdata: m_wdata, rdy: 1'b0, bsy: 1'b1,
                    idone: m_idone, err: m_err};
        r.rdata = rdata;
        exp_q.push_back(r);
    endtask

    // One bus access: setup, strobe, hold; a poll drives its busy bit only on the last strobe cycle
    task automatic push_access(input bit is_poll, input bit bz);
        logic [7:0] d;
        repeat (P_SET) push(1'b0, 1'b0, rnd8());
        for (int i = 0; i < P_EH; i++) begin
            d = rnd8();
            if (is_poll && i == P_EH - 1) d = bz ? (d | 8'h80) : (d & 8'h7F);
            push(is_poll, !is_poll, d);
        end
        repeat (P_HOLD) push(1'b0, 1'b0, rnd8());
    endtask

    task automatic push_polls();
        int nb, n;
        nb = (poll_mode < 0) ? int'($urandom_range(0, 4)) : poll_mode;
        n  = (nb >= P_PL) ? P_PL : nb + 1;
        m_addr = 2'b01;
        for (int p = 0; p < n; p++) push_access(1'b1, p < nb);
        if (nb >= P_PL) m_err = 1'b1;
    endtask

    task automatic push_init();
        m_addr = 2'b00; m_wdata = 8'h00; m_idone = 1'b0; m_err = 1'b0;
        repeat (P_PWR) push(1'b0, 1'b0, rnd8());
        for (int i = 0; i < 6; i++) begin
            push(1'b0, 1'b0, rnd8());
            m_addr  = 2'b00;
            m_wdata = rom[i];
            push_access(1'b0, 1'b0);
            if (i < 3) repeat (P_GAP) push(1'b0, 1'b0, rnd8());
            else push_polls();
        end
        m_idone = 1'b1;
    endtask

    task automatic tick();
        rec_t e;
        obs_t got;
        bit   strobe;
        @(negedge clk);
        cyc      = cyc_next;
        cyc_next = cyc + 1;
        got      = {av_read, av_write, av_address, av_writedata, in_ready, busy, init_done, error};
        e        = '0;
        if (model_on) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
            end else begin
                e.o     = '{rd: 1'b0, wr: 1'b0, addr: m_addr, wdata: m_wdata, rdy: m_idone,
                            bsy: 1'b0, idone: m_idone, err: m_err};
                e.rdata = rnd8();
            end
            check($sformatf("outputs cyc %0d", cyc), 32'(got), 32'(e.o));
            check($sformatf("rd/wr overlap cyc %0d", cyc), 32'(av_read & av_write), 32'd0);
            strobe = av_read | av_write;
            if (av_write && !prev_wr) begin
                wr_cyc.push_back(cyc);
                wr_dat.push_back(av_writedata);
                wr_adr.push_back(av_address);
            end
            if (av_read && !prev_rd) rd_pulses++;
            if (strobe && !prev_strobe) begin
                if (seen_strobe) check_min("E-low gap", low_run, P_SET + P_HOLD);
                seen_strobe = 1'b1;
            end
            low_run = strobe ? 0 : low_run + 1;
            if (init_done && !prev_idone) idone_cyc = cyc;
            prev_wr = av_write; prev_rd = av_read; prev_strobe = strobe; prev_idone = init_done;
        end
        av_readdata = e.rdata;
        reset       = drv_rst;
        in_valid    = drv_valid;
        in_rs       = drv_rs;
        in_data     = drv_data;
        last_acc    = 1'b0;
        if (drv_rst) begin
            exp_q.delete();
            push_init();
            model_on = 1'b1;
            cyc_next = 0;
            seen_strobe = 1'b0;
            wr_cyc.delete(); wr_dat.delete(); wr_adr.delete();
        end else if (model_on && e.o.rdy && drv_valid) begin
            m_addr  = {drv_rs, 1'b0};
            m_wdata = drv_data;
            push_access(1'b0, 1'b0);
            push_polls();
            last_acc = 1'b1;
            acc_cyc  = cyc;
        end
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (!(exp_q.size() == 0 && m_idone) && k < budget) begin
            tick();
            k++;
        end
        if (k >= budget) timeout("wait for idle");
        tick();
    endtask

    task automatic send(input bit rs, input logic [7:0] d, input int budget);
        int k = 0;
        drv_valid = 1'b1; drv_rs = rs; drv_data = d;
        do begin
            tick();
            k++;
        end while (!last_acc && k < budget);
        drv_valid = 1'b0; drv_rs = 1'($urandom); drv_data = rnd8();
        if (!last_acc) timeout("byte acceptance");
    endtask

    task automatic do_reset(input int n);
        drv_rst = 1'b1;
        repeat (n) tick();
        drv_rst = 1'b0;
    endtask

    initial begin
        int nw, k;
        poll_mode = 0; n_checks = 0; n_fail = 0; model_on = 1'b0;
        drv_valid = 1'b0; drv_rs = 1'b0; drv_data = 8'h00; cyc_next = 0;
        rd_pulses = 0; low_run = 0; idone_cyc = -1;
        prev_wr = 0; prev_rd = 0; prev_strobe = 0; prev_idone = 0; seen_strobe = 0;

        // Power-up init with an always-ready LCD
        do_reset(3);
        wait_idle(400);
        check("init write count", 32'(wr_cyc.size()), 32'd6);
        for (int i = 0; i < wr_cyc.size() && i < 6; i++) begin
            check($sformatf("init write %0d data", i), 32'(wr_dat[i]), 32'(rom[i]));
            check($sformatf("init write %0d addr", i), 32'(wr_adr[i]), 32'd0);
        end
        if (wr_cyc.size() > 0) check("first write cycle", 32'(wr_cyc[0]), 32'd23);
        check("init_done rise cycle", 32'(idone_cyc), 32'd128);

        // Character write then a single clean poll
        rd_pulses = 0; nw = wr_cyc.size();
        send(1'b1, 8'h41, 50);
        wait_idle(200);
        check("char write count", 32'(wr_cyc.size()), 32'(nw + 1));
        if (wr_cyc.size() > nw) begin
            check("char address", 32'(wr_adr[nw]), 32'd2);
            check("char data", 32'(wr_dat[nw]), 32'h41);
            check("accept to write latency", 32'(wr_cyc[nw] - acc_cyc), 32'd3);
        end
        check("char poll count", 32'(rd_pulses), 32'd1);

        // Two busy polls then ready
        poll_mode = 2; rd_pulses = 0;
        send(1'b0, 8'h01, 50);
        wait_idle(200);
        check("busy x2 poll count", 32'(rd_pulses), 32'd3);
        check("busy x2 error", 32'(error), 32'd0);

        // Permanently busy: timeout
        poll_mode = 99; rd_pulses = 0;
        send(1'b0, 8'h02, 50);
        wait_idle(200);
        check("timeout poll count", 32'(rd_pulses), 32'd3);
        check("timeout error", 32'(error), 32'd1);
        check("timeout in_ready", 32'(in_ready), 32'd1);
        poll_mode = 0;
        send(1'b1, 8'h42, 50);
        wait_idle(200);
        check("error sticky", 32'(error), 32'd1);

        // Reset in the middle of a data strobe
        send(1'b1, 8'h43, 50);
        k = 0;
        while (!av_write && k < 20) begin tick(); k++; end
        if (k >= 20) timeout("strobe before reset");
        do_reset(1);
        tick();
        check("write after mid-strobe reset", 32'(av_write), 32'd0);
        check("init_done after reset", 32'(init_done), 32'd0);
        check("error after reset", 32'(error), 32'd0);
        wait_idle(400);
        if (wr_cyc.size() > 0) begin
            check("re-init first data", 32'(wr_dat[0]), 32'h38);
            check("re-init first cycle", 32'(wr_cyc[0]), 32'd23);
        end else timeout("re-init first write");

        // Randomized back-to-back traffic with random busy behaviour
        poll_mode = -1;
        for (int i = 0; i < 1500; i++) begin
            drv_valid = ($urandom_range(0, 3) != 0);
            drv_rs    = 1'($urandom);
            drv_data  = rnd8();
            drv_rst   = (i == 700);
            tick();
        end
        drv_rst = 1'b0; drv_valid = 1'b0;
        wait_idle(600);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1, "watchdog");
    end
endmodule
